soft_reset_ctl: RTL
===================

Name: soft_reset_ctl

Overview:
- Wishbone-slave requester for the board soft-reset path.
- Accepts a keyed write and acks it before the reset fires.
- Then issues a one-clock soft_reset strobe to the reset generator and watches the generated system reset go high and come back low.
- Keeps status and a saturating reset counter, so software can confirm after reboot that the reset happened. Sits in the control block beside the reset generator; clocked and reset from the power-on domain, never from the reset it requests.

Parameters:
- KEY, 32'h5EC0FFEE, value that must be written to address 0 to request a reset.
- TIMEOUT, 1024, max cycles to wait for sys_reset_i to assert after the strobe (range 2..65535).
- CNT_W, 8, width of the saturating completed-reset counter.

Ports:
- clock_i  in  1  system clock (40 MHz bx clock).
- reset_i  in  1  asynchronous, active-high reset (power-on / hard reset only).
- wb_cyc_i  in  1  bus cycle.
- wb_stb_i  in  1  strobe; held until ack or err.
- wb_we_i  in  1  write enable.
- wb_addr_i  in  2  register address.
- wb_data_i  in  32  write data.
- wb_data_o  out  32  read data.
- wb_ack_o  out  1  transfer acknowledge.
- wb_err_o  out  1  transfer error.
- sys_reset_i  in  1  generated system reset being monitored.
- soft_reset_o  out  1  one-cycle reset request strobe to the reset generator.
- busy_o  out  1  high whenever state != IDLE.

Behaviour:
- Reset values, all asynchronous on reset_i:
  - wb_ack_o=0, wb_err_o=0, wb_data_o=0, soft_reset_o=0, busy_o=0.
  - State = IDLE; count=0; timeout_flag=0; badkey_flag=0.
- Bus timing:
  - A request is cyc_i & stb_i while neither ack_o nor err_o was high the previous cycle.
  - ack_o or err_o is registered: it goes high exactly one cycle after the request is sampled, for exactly one cycle. Ack and err are never high together.
  - wb_data_o is valid in the ack cycle and 0 otherwise.
- Register map:
  - addr 0 (write-only): key.
  - addr 1 (read-only): status. bit0 busy, bit1 timeout_flag, bit2 badkey_flag, bits[5:4] state encoding, rest 0.
  - addr 2 (read): count zero-extended. Write to addr 2 clears count, timeout_flag and badkey_flag.
  - addr 3: reserved (see the optional feature).
  - Any other access, or a write to addr 1 or read of addr 0, gets err.
- Key write, addr 0:
  - IDLE and data==KEY: ack, and state becomes STROBE on the ack cycle.
  - IDLE and data!=KEY: ack, set badkey_flag, stay in IDLE.
  - Any non-IDLE state: err, no state change.
- States (encoding 0..3):
  - IDLE(0).
  - STROBE(1): soft_reset_o=1 for exactly this one cycle, which is the cycle after ack. Next state WAIT_ASSERT.
  - WAIT_ASSERT(2): 16-bit timer counts cycles.
    - sys_reset_i=1 goes to WAIT_RELEASE.
    - If the timer reaches TIMEOUT with sys_reset_i still 0: set timeout_flag and go to IDLE.
    - If both happen in the same cycle, assertion wins.
  - WAIT_RELEASE(3): when sys_reset_i=0, count <= count+1 saturating at 2^CNT_W-1, then IDLE. No timeout here.
- sys_reset_i already high at STROBE still passes through WAIT_ASSERT; it is detected on the first cycle there.
- Bus reads and addr-2 writes are served in every state.
- A clear on addr 2 in the same cycle as a count increment: clear wins.
- reset_i asserted mid-sequence aborts immediately to IDLE; soft_reset_o drops asynchronously.
- busy_o is combinational from state.

Optional Feature:
- Macro SOFT_RESET_UNLOCK_EN.
- Defined:
  - A write of 32'hA5A5_0001 to addr 3 arms an unlock window of 256 cycles (ack).
  - A correct key write outside the window acks but sets badkey_flag and does not reset.
  - Any key write closes the window.
  - A read of addr 3 returns bit0 = window open.
- Undefined: addr 3 returns err for all accesses; the key alone suffices.

Decomposition:
- Shared package: state typedef (IDLE/STROBE/WAIT_ASSERT/WAIT_RELEASE), register address constants, status bit indices, the unlock constant.
- Natural sub-module: soft_reset_wb_regs (bus decode, ack/err generation, register storage). The FSM stays in the top.

Test Plan:
- Write 5EC0FFEE to addr 0 in IDLE -> ack 1 cycle later; soft_reset_o high exactly the next cycle. Drive sys_reset_i high 300 cycles later for 64 cycles -> count reads 1, busy returns to 0.
- Write 12345678 to addr 0 -> ack, no soft_reset_o, status reads 0x4.
- Correct key with sys_reset_i held 0, TIMEOUT=1024 -> return to IDLE exactly 1024 cycles into WAIT_ASSERT; status reads 0x2; count stays 0.
- Key write while in WAIT_RELEASE -> err, state unchanged. Read addr 1 in the same state -> ack with bits[5:4]=3.
- Force count to 255 and complete another sequence -> count stays 255. Write addr 2 -> count 0, flags 0.
- Assert reset_i during WAIT_ASSERT -> all outputs 0 within the same cycle; IDLE on release. With SOFT_RESET_UNLOCK_EN: key without unlock -> badkey set, no strobe; unlock then key within 256 cycles -> strobe.

Source files
------------

// File: rtl/soft_reset_pkg.sv
// Shared state type, register map and unlock constants for the soft-reset requester.
// Helper functions keep the unlock constants referenced whether or not SOFT_RESET_UNLOCK_EN is set.
package soft_reset_pkg;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_STROBE       = 2'd1,
    ST_WAIT_ASSERT  = 2'd2,
    ST_WAIT_RELEASE = 2'd3
  } state_t;

  localparam logic [1:0] ADDR_KEY    = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;
  localparam logic [1:0] ADDR_UNLOCK = 2'd3;

  localparam int STAT_BUSY      = 0;
  localparam int STAT_TIMEOUT   = 1;
  localparam int STAT_BADKEY    = 2;
  localparam int STAT_STATE_LSB = 4;

  localparam logic [31:0] UNLOCK_MAGIC  = 32'hA5A5_0001;
  localparam int          UNLOCK_WINDOW = 256;

  function automatic logic [31:0] status_word(input state_t st, input logic to_flag,
                                              input logic bk_flag);
    logic [31:0] w;
    w                         = '0;
    w[STAT_BUSY]              = (st != ST_IDLE);
    w[STAT_TIMEOUT]           = to_flag;
    w[STAT_BADKEY]            = bk_flag;
    w[STAT_STATE_LSB +: 2]    = st;
    return w;
  endfunction

  function automatic logic is_unlock(input logic [31:0] d);
    return d == UNLOCK_MAGIC;
  endfunction

  function automatic logic [8:0] window_init();
    return 9'(UNLOCK_WINDOW);
  endfunction

endpackage

// File: rtl/soft_reset_wb_regs.sv
// Wishbone decode, registered ack/err (one cycle after the request) and status/counter storage.
// SOFT_RESET_UNLOCK_EN: addr 3 arms a 256-cycle window that a key write must fall inside.
module soft_reset_wb_regs
  import soft_reset_pkg::*;
#(
  parameter logic [31:0] KEY   = 32'h5EC0FFEE,
  parameter int          CNT_W = 8
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [1:0]  wb_addr_i,
  input  logic [31:0] wb_data_i,
  output logic [31:0] wb_data_o,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  input  state_t      state_i,
  input  logic        cnt_inc_i,
  input  logic        timeout_set_i,
  output logic        start_o
);

  logic             ack_q, ack_d, err_q, err_d, start_q, start_d;
  logic             timeout_q, timeout_d, badkey_q, badkey_d;
  logic [31:0]      dat_q, dat_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             req, clr, badkey_set, key_ok;

`ifdef SOFT_RESET_UNLOCK_EN
  logic [8:0] win_q, win_d;
  logic       win_open, arm, key_wr;
  assign win_open = (win_q != '0);
  assign key_ok   = (wb_data_i == KEY) && win_open;
  assign key_wr   = req && wb_we_i && (wb_addr_i == ADDR_KEY);
`else
  assign key_ok   = (wb_data_i == KEY);
`endif

  // A held strobe is not re-sampled while its own ack/err is on the bus.
  assign req = wb_cyc_i && wb_stb_i && !ack_q && !err_q;

  always_comb begin
    ack_d      = 1'b0;
    err_d      = 1'b0;
    dat_d      = '0;
    start_d    = 1'b0;
    clr        = 1'b0;
    badkey_set = 1'b0;
`ifdef SOFT_RESET_UNLOCK_EN
    arm        = 1'b0;
`endif
    if (req) begin
      if (wb_we_i) begin
        case (wb_addr_i)
          ADDR_KEY: begin
            if (state_i == ST_IDLE) begin
              ack_d = 1'b1;
              if (key_ok) start_d = 1'b1;
              else        badkey_set = 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end
          ADDR_COUNT: begin
            ack_d = 1'b1;
            clr   = 1'b1;
          end
`ifdef SOFT_RESET_UNLOCK_EN
          ADDR_UNLOCK: begin
            if (is_unlock(wb_data_i)) begin
              ack_d = 1'b1;
              arm   = 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end
`endif
          default: err_d = 1'b1;
        endcase
      end else begin
        case (wb_addr_i)
          ADDR_STATUS: begin
            ack_d = 1'b1;
            dat_d = status_word(state_i, timeout_q, badkey_q);
          end
          ADDR_COUNT: begin
            ack_d = 1'b1;
            dat_d = 32'(cnt_q);
          end
`ifdef SOFT_RESET_UNLOCK_EN
          ADDR_UNLOCK: begin
            ack_d = 1'b1;
            dat_d = {31'b0, win_open};
          end
`endif
          default: err_d = 1'b1;
        endcase
      end
    end

    // Software clear takes priority over any same-cycle flag set or count increment.
    timeout_d = clr ? 1'b0 : (timeout_q | timeout_set_i);
    badkey_d  = clr ? 1'b0 : (badkey_q | badkey_set);
    if (clr)                          cnt_d = '0;
    else if (cnt_inc_i && cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
    else                              cnt_d = cnt_q;

`ifdef SOFT_RESET_UNLOCK_EN
    if (arm)                 win_d = window_init();
    else if (key_wr)         win_d = '0;
    else if (win_q != '0)    win_d = win_q - 9'd1;
    else                     win_d = win_q;
`endif
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      dat_q     <= '0;
      start_q   <= 1'b0;
      timeout_q <= 1'b0;
      badkey_q  <= 1'b0;
      cnt_q     <= '0;
`ifdef SOFT_RESET_UNLOCK_EN
      win_q     <= '0;
`endif
    end else begin
      ack_q     <= ack_d;
      err_q     <= err_d;
      dat_q     <= dat_d;
      start_q   <= start_d;
      timeout_q <= timeout_d;
      badkey_q  <= badkey_d;
      cnt_q     <= cnt_d;
`ifdef SOFT_RESET_UNLOCK_EN
      win_q     <= win_d;
`endif
    end
  end

  assign wb_ack_o  = ack_q;
  assign wb_err_o  = err_q;
  assign wb_data_o = dat_q;
  assign start_o   = start_q;

endmodule

// File: rtl/soft_reset_ctl.sv
// Soft-reset requester: keyed Wishbone write -> one-cycle soft_reset_o -> watch sys_reset_i rise and fall.
// Bus ack/err one cycle after request; build option SOFT_RESET_UNLOCK_EN gates the key behind an unlock window.
module soft_reset_ctl
  import soft_reset_pkg::*;
#(
  parameter logic [31:0] KEY     = 32'h5EC0FFEE,
  parameter int          TIMEOUT = 1024,
  parameter int          CNT_W   = 8
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [1:0]  wb_addr_i,
  input  logic [31:0] wb_data_i,
  output logic [31:0] wb_data_o,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  input  logic        sys_reset_i,
  output logic        soft_reset_o,
  output logic        busy_o
);

  localparam logic [15:0] TIMEOUT_M1 = 16'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic        start, cnt_inc, timeout_set;

  soft_reset_wb_regs #(
    .KEY   (KEY),
    .CNT_W (CNT_W)
  ) u_regs (
    .clock_i       (clock_i),
    .reset_i       (reset_i),
    .wb_cyc_i      (wb_cyc_i),
    .wb_stb_i      (wb_stb_i),
    .wb_we_i       (wb_we_i),
    .wb_addr_i     (wb_addr_i),
    .wb_data_i     (wb_data_i),
    .wb_data_o     (wb_data_o),
    .wb_ack_o      (wb_ack_o),
    .wb_err_o      (wb_err_o),
    .state_i       (state_q),
    .cnt_inc_i     (cnt_inc),
    .timeout_set_i (timeout_set),
    .start_o       (start)
  );

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    cnt_inc     = 1'b0;
    timeout_set = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_STROBE;
      end
      ST_STROBE: begin
        timer_d = '0;
        state_d = ST_WAIT_ASSERT;
      end
      ST_WAIT_ASSERT: begin
        // timer_q counts completed cycles here, so the last allowed cycle sees TIMEOUT-1.
        if (sys_reset_i) begin
          state_d = ST_WAIT_RELEASE;
        end else if (timer_q == TIMEOUT_M1) begin
          timeout_set = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      ST_WAIT_RELEASE: begin
        if (!sys_reset_i) begin
          cnt_inc = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  assign soft_reset_o = (state_q == ST_STROBE);
  assign busy_o       = (state_q != ST_IDLE);

endmodule
